// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and two's-complement helpers for the iterative multiply/divide unit.
package mult_div_unit_pkg;

   localparam int unsigned ITER = 32;
   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIX  = 2'b10,
      S_DONE = 2'b11
   } state_e;

   // Helpers work on the widest value (a full product); callers truncate.
   function automatic logic [2*XLEN-1:0] neg(input logic [2*XLEN-1:0] x);
      return ~x + (2*XLEN)'(1);
   endfunction

   function automatic logic [2*XLEN-1:0] abs_val(input logic [2*XLEN-1:0] x, input logic s);
      return s ? neg(x) : x;
   endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; one bit per cycle,
// sign correction applied in a final FIX cycle.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned ITER  = mult_div_unit_pkg::ITER
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

   state_e             state;
   op_e                op_q;
   logic               sgn_a, sgn_b;
   logic [WIDTH-1:0]   opb;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      cnt;

   logic               signed_in, sa_in, sb_in, zero_div, is_div_q;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mult_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0] mult_next, div_next, prod;
   logic [WIDTH-1:0]   fix_hi, fix_lo;
   logic               fix_dbz;

   always_comb begin
      signed_in = ~op[0];
      sa_in     = signed_in & a[WIDTH-1];
      sb_in     = signed_in & b[WIDTH-1];
      mag_a     = WIDTH'(abs_val((2*XLEN)'(a), sa_in));
      mag_b     = WIDTH'(abs_val((2*XLEN)'(b), sb_in));
      zero_div  = op[1] && (b == '0);
      is_div_q  = (op_q == OP_DIV) || (op_q == OP_DIVU);
   end

   // acc: multiply = {partial product, remaining multiplier};
   //      divide   = {partial remainder, remaining dividend / quotient bits}.
   always_comb begin
      mult_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : '0)};
      mult_next = {mult_sum, acc[WIDTH-1:1]};
      div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opb};
      if (div_diff[WIDTH])
         div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
         div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
   end

   always_comb begin
      prod    = acc;
      fix_hi  = acc[2*WIDTH-1:WIDTH];
      fix_lo  = acc[WIDTH-1:0];
      fix_dbz = 1'b0;
      if (is_div_q) begin
         // A zero divisor skipped RUN with {a, all-ones} preloaded into acc.
         if (opb == '0) begin
            fix_dbz = 1'b1;
         end else if (op_q == OP_DIV) begin
            if (sgn_a ^ sgn_b) fix_lo = WIDTH'(neg((2*XLEN)'(acc[WIDTH-1:0])));
            if (sgn_a)         fix_hi = WIDTH'(neg((2*XLEN)'(acc[2*WIDTH-1:WIDTH])));
         end
      end else begin
         if ((op_q == OP_MULT) && (sgn_a ^ sgn_b))
            prod = (2*WIDTH)'(neg((2*XLEN)'(acc)));
         fix_hi = prod[2*WIDTH-1:WIDTH];
         fix_lo = prod[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         op_q        <= OP_MULT;
         sgn_a       <= 1'b0;
         sgn_b       <= 1'b0;
         opb         <= '0;
         acc         <= '0;
         cnt         <= '0;
         hi          <= '0;
         lo          <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         if (!busy && wr_hi) hi <= wdata;
         if (!busy && wr_lo) lo <= wdata;
         case (state)
            S_IDLE, S_DONE: begin
               done <= 1'b0;
               if (start) begin
                  op_q        <= op_e'(op);
                  sgn_a       <= sa_in;
                  sgn_b       <= sb_in;
                  opb         <= mag_b;
                  acc         <= zero_div ? {a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, mag_a};
                  cnt         <= '0;
                  busy        <= 1'b1;
                  div_by_zero <= 1'b0;
                  state       <= zero_div ? S_FIX : S_RUN;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_RUN: begin
               acc <= is_div_q ? div_next : mult_next;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(ITER - 1)) state <= S_FIX;
            end
            S_FIX: begin
               hi          <= fix_hi;
               lo          <= fix_lo;
               div_by_zero <= fix_dbz;
               busy        <= 1'b0;
               done        <= 1'b1;
               state       <= S_DONE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table through a result scoreboard,
// plus hand sequences for start-while-busy, HI/LO writes and mid-operation reset.
module tb_mult_div_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a, b, wdata;
   logic        wr_hi, wr_lo;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int          lat;
      int          bsy;
   } vec_t;

   vec_t        vecs[12];
   vec_t        sb[$];
   logic [31:0] model_hi, model_lo;

   mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog act=running req=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h req=%0h", name, act, exp);
      end
   endtask

   // Runs one operation; optionally pulses a second start at pulse_at, a wr_lo at
   // wr_at (both while busy), or a wr_hi on the accepting edge itself.
   task automatic run_op(input vec_t v, input int pulse_at, input int wr_at, input logic wr_with_start);
      int   lat;
      int   bc;
      vec_t e;
      sb.push_back(v);
      op = v.op; a = v.a; b = v.b; start = 1'b1;
      if (wr_with_start) begin wr_hi = 1'b1; wdata = 32'h0000ABCD; end
      tick;
      start = 1'b0;
      check("busy_after_start", busy, 1);
      if (wr_with_start) begin
         wr_hi = 1'b0;
         check("hi_wr_with_start", hi, 32'h0000ABCD);
      end
      lat = 1;
      bc  = busy ? 1 : 0;
      while (!done && lat < 100) begin
         if (lat == pulse_at) begin start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3; end
         if (lat == wr_at)    begin wr_lo = 1'b1; wdata = 32'h0000DEAD; end
         tick;
         start = 1'b0;
         wr_lo = 1'b0;
         if (lat == wr_at) check("lo_hold_busy", lo, model_lo);
         lat++;
         if (busy) bc++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout act=no_done req=done");
         void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         check("hi",          hi, e.hi);
         check("lo",          lo, e.lo);
         check("div_by_zero", div_by_zero, e.dbz);
         check("latency",     lat, e.lat);
         check("busy_cycles", bc, e.bsy);
         check("busy_at_done", busy, 0);
         model_hi = e.hi;
         model_lo = e.lo;
      end
   endtask

   initial begin
      int   cnt;
      vec_t v;

      vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34, 33};
      vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34, 33};
      vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34, 33};
      vecs[3]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34, 33};
      vecs[4]  = '{2'b11, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1, 2,  1};
      vecs[5]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34, 33};
      vecs[6]  = '{2'b00, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988, 1'b0, 34, 33};
      vecs[7]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34, 33};
      vecs[8]  = '{2'b01, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000, 1'b0, 34, 33};
      vecs[9]  = '{2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 2,  1};
      vecs[10] = '{2'b00, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006, 1'b0, 34, 33};
      vecs[11] = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 34, 33};

      rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
      wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
      model_hi = '0; model_lo = '0;
      tick; tick;
      rst_n = 1'b1;
      tick;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_dbz",  div_by_zero, 0);
      check("rst_hi",   hi, 0);
      check("rst_lo",   lo, 0);

      // Consecutive vectors start in the DONE cycle of the previous one.
      for (int i = 0; i < 12; i++) run_op(vecs[i], 0, 0, 1'b0);

      // Start pulsed while busy must be dropped, not queued.
      tick; tick;
      run_op(vecs[5], 5, 0, 1'b0);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick;
         if (done || busy) cnt++;
      end
      check("ignored_start_no_activity", cnt, 0);

      // HI write in IDLE.
      wr_hi = 1'b1; wdata = 32'h00001234;
      tick;
      wr_hi = 1'b0;
      model_hi = 32'h00001234;
      check("wr_hi_idle_hi", hi, model_hi);
      check("wr_hi_idle_lo", lo, model_lo);

      // LO write while busy is dropped; then write on the accepting edge.
      v = '{2'b01, 32'd3, 32'd3, 32'd0, 32'd9, 1'b0, 34, 33};
      run_op(v, 0, 3, 1'b0);
      v = '{2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 34, 33};
      run_op(v, 0, 0, 1'b1);

      // Reset in the middle of a MULT.
      tick;
      op = 2'b00; a = 32'h00000011; b = 32'h00000022; start = 1'b1;
      tick;
      start = 1'b0;
      for (int i = 0; i < 9; i++) tick;
      check("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_hi",   hi, 0);
      check("midrst_lo",   lo, 0);
      tick;
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 50; i++) begin
         tick;
         if (done) cnt++;
      end
      check("no_done_after_rst", cnt, 0);
      check("sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
